// File: rtl/pwm_ramp_ctrl.sv
// Soft-start duty scheduler: slews four 8-bit PWM duties toward commanded targets.
// Optional command watchdog enabled by defining PWM_RAMP_WDT_EN.
module pwm_ramp_ctrl #(
    parameter int unsigned RAMP_DIV   = 256,
    parameter int unsigned STEP       = 4,
    parameter int unsigned WDT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_ch,
    input  logic [7:0]  cmd_duty,
    input  logic        estop,
    output logic [31:0] num,
    output logic        busy,
    output logic [3:0]  at_target,
    output logic        wdt_fired
);

    typedef enum logic [1:0] {IDLE, RAMP, ESTOP} state_t;

    localparam int unsigned TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);
    localparam logic [8:0] STEP9 = (STEP >= 255) ? 9'd255 : 9'(STEP);

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0][7:0] cur_q, cur_d;
    logic [3:0][7:0] tgt_q, tgt_d;
    logic [3:0]      at_target_q, at_target_d;
    logic            tick;
    logic            accept;
    logic            any_diff;
    logic            wdt_trip;

    assign cmd_ready = (state_q != ESTOP);
    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (tick_cnt_q == TICK_LAST);
    assign any_diff  = (cur_q != tgt_q);
    assign num       = cur_q;
    assign busy      = (state_q == RAMP);
    assign at_target = at_target_q;

    // 9-bit differences so a large gap never wraps or overshoots
    function automatic logic [7:0] slew(input logic [7:0] cur,
                                        input logic [7:0] tgt);
        logic [8:0] diff;
        logic [8:0] d;
        diff = 9'd0;
        d    = 9'd0;
        slew = cur;
        if (tgt > cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            d    = (diff < STEP9) ? diff : STEP9;
            slew = cur + d[7:0];
        end else if (cur > tgt) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            d    = (diff < STEP9) ? diff : STEP9;
            slew = cur - d[7:0];
        end
    endfunction

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        cur_d      = cur_q;
        tgt_d      = tgt_q;
        state_d    = state_q;
        for (int i = 0; i < 4; i++) begin
            at_target_d[i] = (cur_q[i] == tgt_q[i]);
        end
        if (estop) begin
            cur_d   = '0;
            tgt_d   = '0;
            state_d = ESTOP;
        end else begin
            if (tick) begin
                for (int i = 0; i < 4; i++) begin
                    cur_d[i] = slew(cur_q[i], tgt_q[i]);
                end
            end
            if (wdt_trip) tgt_d = '0;
            if (accept) tgt_d[cmd_ch] = cmd_duty;
            unique case (state_q)
                IDLE:    if (any_diff) state_d = RAMP;
                RAMP:    if (!any_diff) state_d = IDLE;
                ESTOP:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            cur_q       <= '0;
            tgt_q       <= '0;
            at_target_q <= 4'hF;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            at_target_q <= at_target_d;
        end
    end

`ifdef PWM_RAMP_WDT_EN
    localparam int unsigned WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic          wdt_fired_q, wdt_fired_d;

    assign wdt_fired = wdt_fired_q;

    // Counter parks at WDT_LAST after a trip until the next accepted command
    always_comb begin
        wdt_cnt_d   = wdt_cnt_q;
        wdt_fired_d = wdt_fired_q;
        wdt_trip    = 1'b0;
        if (estop || state_q == ESTOP) begin
            wdt_cnt_d = '0;
        end else if (accept) begin
            wdt_cnt_d   = '0;
            wdt_fired_d = 1'b0;
        end else if (wdt_cnt_q == WDT_LAST) begin
            wdt_trip    = 1'b1;
            wdt_fired_d = 1'b1;
        end else begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end
`else
    localparam int unsigned wdt_cycles_unused = WDT_CYCLES;

    assign wdt_trip  = 1'b0;
    assign wdt_fired = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: per-cycle scoreboard plus directed scenarios.
// Define PWM_RAMP_WDT_EN to also exercise the watchdog.
module tb_pwm_ramp_ctrl;

    localparam int RD = 4;
    localparam int ST = 4;
    localparam int WD = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ch = 2'd0;
    logic [7:0]  cmd_duty = 8'd0;
    logic        estop = 1'b0;
    logic [31:0] num;
    logic        busy;
    logic [3:0]  at_target;
    logic        wdt_fired;

    pwm_ramp_ctrl #(
        .RAMP_DIV   (RD),
        .STEP       (ST),
        .WDT_CYCLES (WD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_duty  (cmd_duty),
        .estop     (estop),
        .num       (num),
        .busy      (busy),
        .at_target (at_target),
        .wdt_fired (wdt_fired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] num;
        logic [3:0]  at;
        logic        busy;
        logic        rdy;
        logic        wdt;
    } exp_t;

    exp_t sb_q[$];
    exp_t push_e;
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: integer arithmetic, updated once per rising edge
    int       m_cur[4];
    int       m_tgt[4];
    int       m_tick;
    int       m_st;
    int       m_wc;
    logic [3:0] m_at;
    bit       m_wf;
    bit       m_rdy, m_acc, m_tk, m_diff, m_trip;

    function automatic int slew(input int c, input int t);
        if (t > c) return c + (((t - c) < ST) ? (t - c) : ST);
        if (c > t) return c - (((c - t) < ST) ? (c - t) : ST);
        return c;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                m_cur[i] = 0;
                m_tgt[i] = 0;
            end
            m_st   = 0;
            m_tick = 0;
            m_at   = 4'hF;
            m_wc   = 0;
            m_wf   = 1'b0;
        end else begin
            m_rdy  = (m_st != 2);
            m_acc  = cmd_valid && m_rdy;
            m_tk   = (m_tick == RD - 1);
            m_diff = 1'b0;
            m_trip = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_cur[i] != m_tgt[i]) m_diff = 1'b1;
                m_at[i] = (m_cur[i] == m_tgt[i]);
            end
`ifdef PWM_RAMP_WDT_EN
            if (estop || m_st == 2) m_wc = 0;
            else if (m_acc) begin
                m_wc = 0;
                m_wf = 1'b0;
            end else if (m_wc == WD - 1) begin
                m_wf   = 1'b1;
                m_trip = 1'b1;
            end else m_wc++;
`endif
            if (estop) begin
                for (int i = 0; i < 4; i++) begin
                    m_cur[i] = 0;
                    m_tgt[i] = 0;
                end
                m_st = 2;
            end else begin
                if (m_tk)
                    for (int i = 0; i < 4; i++) m_cur[i] = slew(m_cur[i], m_tgt[i]);
                if (m_trip)
                    for (int i = 0; i < 4; i++) m_tgt[i] = 0;
                if (m_acc) m_tgt[cmd_ch] = int'(cmd_duty);
                if (m_st == 2) m_st = 0;
                else if (m_st == 0 && m_diff) m_st = 1;
                else if (m_st == 1 && !m_diff) m_st = 0;
            end
            m_tick = (m_tick + 1) % RD;
        end
        push_e.num  = {8'(m_cur[3]), 8'(m_cur[2]), 8'(m_cur[1]), 8'(m_cur[0])};
        push_e.at   = m_at;
        push_e.busy = (m_st == 1);
        push_e.rdy  = (m_st != 2);
        push_e.wdt  = m_wf;
        sb_q.push_back(push_e);
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("sb_num", num, mon_e.num);
            chk("sb_at", {28'd0, at_target}, {28'd0, mon_e.at});
            chk("sb_busy", {31'd0, busy}, {31'd0, mon_e.busy});
            chk("sb_rdy", {31'd0, cmd_ready}, {31'd0, mon_e.rdy});
            chk("sb_wdt", {31'd0, wdt_fired}, {31'd0, mon_e.wdt});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic send(input logic [1:0] ch, input logic [7:0] duty);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_duty  = duty;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_num(input string tag, input logic [31:0] mask,
                            input logic [31:0] val, input int budget);
        int k = 0;
        while (((num & mask) !== val) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, num & mask, val);
    endtask

    function automatic int pick(input int q[$], input int k);
        return (q.size() > k) ? q[k] : -1;
    endfunction

    int seen[$];
    int last;
    bit bsy;
    int k;

    initial begin
        // reset
        repeat (2) @(negedge clk);
        chk("rst_num", num, 32'h0);
        chk("rst_rdy", {31'd0, cmd_ready}, 32'd1);
        chk("rst_at", {28'd0, at_target}, 32'hF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wdt", {31'd0, wdt_fired}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ch0 ramps 4, 8, 10
        send(2'd0, 8'd10);
        seen = {};
        last = int'(num[7:0]);
        bsy  = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (busy) bsy = 1'b1;
            if (int'(num[7:0]) != last) begin
                last = int'(num[7:0]);
                seen.push_back(last);
            end
        end
        chk("ch0_nsteps", seen.size(), 3);
        chk("ch0_s0", pick(seen, 0), 4);
        chk("ch0_s1", pick(seen, 1), 8);
        chk("ch0_s2", pick(seen, 2), 10);
        chk("ch0_busy_seen", {31'd0, bsy}, 32'd1);
        chk("ch0_busy_end", {31'd0, busy}, 32'd0);
        chk("ch0_num", num, 32'h0000000A);

        // ch2 0x40 -> 0x3E in one partial step
        send(2'd2, 8'h40);
        wait_num("ch2_up", 32'h00FF0000, 32'h00400000, 100);
        k = 0;
        while (busy && k < 6) begin
            @(negedge clk);
            k++;
        end
        chk("ch2_idle", {31'd0, busy}, 32'd0);
        send(2'd2, 8'h3E);
        k = 0;
        while (num[23:16] == 8'h40 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("ch2_step", {24'd0, num[23:16]}, 32'h3E);
        chk("ch2_at_lag", {31'd0, at_target[2]}, 32'd0);
        @(negedge clk);
        chk("ch2_at", {31'd0, at_target[2]}, 32'd1);

        // estop mid-ramp of ch1
        send(2'd1, 8'd100);
        k = 0;
        while (num[15:8] == 8'd0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        estop = 1'b1;
        @(negedge clk);
        chk("estop_num", num, 32'h0);
        chk("estop_rdy", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1;
        cmd_ch    = 2'd1;
        cmd_duty  = 8'd200;
        repeat (2) @(negedge clk);
        chk("estop_hold", num, 32'h0);
        estop     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("estop_rel_rdy", {31'd0, cmd_ready}, 32'd1);
        chk("estop_rel_at", {28'd0, at_target}, 32'hF);
        repeat (10) @(negedge clk);
        chk("estop_no_ramp", num, 32'h0);
        chk("estop_idle", {31'd0, busy}, 32'd0);

        // back-to-back ch3 commands, then ch1 on a tick cycle
        send(2'd3, 8'hFF);
        send(2'd3, 8'h08);
        k = 0;
        while (m_tick != RD - 1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        send(2'd1, 8'h20);
        chk("ch1_hold", {24'd0, num[15:8]}, 32'd0);
        repeat (RD) @(negedge clk);
        chk("ch1_move", {24'd0, num[15:8]}, 32'd4);
        wait_num("ch3_settle", 32'hFF000000, 32'h08000000, 40);
        repeat (8) @(negedge clk);
        chk("ch3_stay", {24'd0, num[31:24]}, 32'd8);

`ifdef PWM_RAMP_WDT_EN
        // watchdog trip ramps ch0 down from 20
        send(2'd0, 8'd20);
        wait_num("wdt_ch0_up", 32'h000000FF, 32'd20, 40);
        k = 0;
        while (!wdt_fired && k < 150) begin
            @(negedge clk);
            k++;
        end
        chk("wdt_fire", {31'd0, wdt_fired}, 32'd1);
        seen = {};
        last = int'(num[7:0]);
        repeat (30) begin
            @(negedge clk);
            if (int'(num[7:0]) != last) begin
                last = int'(num[7:0]);
                seen.push_back(last);
            end
        end
        chk("wdt_nsteps", seen.size(), 5);
        chk("wdt_s0", pick(seen, 0), 16);
        chk("wdt_s4", pick(seen, 4), 0);
        chk("wdt_sticky", {31'd0, wdt_fired}, 32'd1);
        send(2'd2, 8'd5);
        chk("wdt_clear", {31'd0, wdt_fired}, 32'd0);
`else
        repeat (150) @(negedge clk);
        chk("wdt_off", {31'd0, wdt_fired}, 32'd0);
`endif

        // reset mid-ramp
        send(2'd0, 8'd200);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_num", num, 32'h0);
        chk("rst2_at", {28'd0, at_target}, 32'hF);
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        chk("rst2_wdt", {31'd0, wdt_fired}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
